// File: rtl/sram_bank_ctrl.sv
// Banked SRAM controller: NUM_BANKS x NUM_COLS 512x8 macros behind a valid/ready request port
// and a 3-deep response FIFO, with a full-array hardware clear after reset or on demand.

// Behavioural stand-in for the foundry 512x8 macro: active-low CEN/GWEN/WEN, registered Q.
module gf180mcu_fd_ip_sram__sram512x8m8wm1 (
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [8:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
`ifdef USE_POWER_PINS
  ,
  inout  wire        VDD,
  inout  wire        VSS
`endif
);
  logic [7:0] mem [512];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      else       Q      <= mem[A];
    end
  end
endmodule

module sram_bank_ctrl #(
  parameter  int         NUM_BANKS  = 2,
  parameter  int         NUM_COLS   = 2,
  parameter  logic [7:0] INIT_VALUE = 8'h00,
  localparam int         DW         = 8 * NUM_COLS,
  localparam int         ADDR_W     = 9 + $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  output logic              init_busy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DW-1:0]     req_wdata,
  input  logic [NUM_COLS-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata
`ifdef USE_POWER_PINS
  ,
  inout  wire               VDD,
  inout  wire               VSS
`endif
);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic {S_INIT, S_IDLE} state_e;

  state_e state_q, state_d;
  logic [8:0] clr_q, clr_d;

  logic [BW-1:0] bank;
  logic          accept;
  logic          inflight_q;
  logic [BW-1:0] rd_bank_q;

  logic [NUM_BANKS-1:0][NUM_COLS-1:0]      cen;
  logic                                    gwen;
  logic [8:0]                              mac_a;
  logic [NUM_COLS-1:0][7:0]                mac_d;
  logic [NUM_BANKS-1:0][NUM_COLS-1:0][7:0] mac_q;

  logic [2:0][DW-1:0] fifo_q;
  logic [1:0]         wptr_q, rptr_q, cnt_q;
  logic               push, pop;
  logic [DW-1:0]      push_data;

  if (NUM_BANKS > 1) begin : g_bank
    assign bank = req_addr[ADDR_W-1:9];
  end else begin : g_nobank
    assign bank = '0;
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      S_INIT: begin
        clr_d = clr_q + 9'd1;
        if (clr_q == 9'd511) state_d = S_IDLE;
      end
      default: begin
        if (init_start) begin
          state_d = S_INIT;
          clr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Credit counts the in-flight read so the FIFO can never overflow; a same-cycle pop is not credited.
  assign init_busy = (state_q == S_INIT);
  assign req_ready = (state_q == S_IDLE) && !init_start &&
                     (({1'b0, cnt_q} + {2'b00, inflight_q}) < 3'd3);
  assign accept    = req_valid && req_ready;

  always_comb begin
    cen   = '1;
    gwen  = 1'b1;
    mac_a = req_addr[8:0];
    mac_d = req_wdata;
    if (state_q == S_INIT) begin
      cen   = '0;
      gwen  = 1'b0;
      mac_a = clr_q;
      mac_d = {NUM_COLS{INIT_VALUE}};
    end else if (accept) begin
      gwen = ~req_we;
      for (int c = 0; c < NUM_COLS; c++)
        cen[bank][c] = req_we ? ~req_wmask[c] : 1'b0;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_b
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_c
      gf180mcu_fd_ip_sram__sram512x8m8wm1 u_mac (
        .CLK  (clk),
        .CEN  (cen[b][c]),
        .GWEN (gwen),
        .WEN  (8'h00),
        .A    (mac_a),
        .D    (mac_d[c]),
        .Q    (mac_q[b][c])
`ifdef USE_POWER_PINS
        ,
        .VDD  (VDD),
        .VSS  (VSS)
`endif
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      inflight_q <= accept && !req_we;
      if (accept && !req_we) rd_bank_q <= bank;
    end
  end

  // Macro Q is valid the cycle after the read strobe; capture it straight into the FIFO.
  assign push      = inflight_q;
  assign push_data = mac_q[rd_bank_q];
  assign rsp_valid = (cnt_q != 2'd0);
  assign rsp_rdata = fifo_q[rptr_q];
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= push_data;
        wptr_q         <= (wptr_q == 2'd2) ? 2'd0 : wptr_q + 2'd1;
      end
      if (pop) rptr_q <= (rptr_q == 2'd2) ? 2'd0 : rptr_q + 2'd1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: doc/sram_bank_ctrl.md
Name: sram_bank_ctrl

Overview:
- Parametrised memory subsystem built from NUM_BANKS x NUM_COLS gf180mcu_fd_ip_sram__sram512x8m8wm1 macros (512x8 each).
- Banks extend depth; columns extend width in byte lanes.
- Presents a valid/ready request port and a buffered valid/ready response port to core logic.
- Performs a hardware clear of the whole array to INIT_VALUE after reset and on demand.

Parameters:
NUM_BANKS, 2, number of 512-row banks; power of two, >=1
NUM_COLS, 2, byte lanes per word; data width DW = 8*NUM_COLS
INIT_VALUE, 8'h00, byte written to every location during clear
Derived: ADDR_W = 9 + $clog2(NUM_BANKS)

Ports:
VDD  inout  1  power, present only under USE_POWER_PINS, to all macros
VSS  inout  1  ground, present only under USE_POWER_PINS, to all macros
clk  input  1  clock; all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
init_start  input  1  pulse: re-run full-array clear
init_busy  output  1  clear in progress
req_valid  input  1  request valid
req_ready  output  1  request accepted when valid&&ready
req_we  input  1  1=write, 0=read
req_addr  input  ADDR_W  word address
req_wdata  input  DW  write data, lane i = bits [8i+7:8i]
req_wmask  input  NUM_COLS  per-lane write enable, 1=write lane
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer accepts read data
rsp_rdata  output  DW  read data, lane order as req_wdata

Behaviour:
- Reset (async assert): state=INIT, clear_ptr=0, init_busy=1, req_ready=0, rsp_valid=0, FIFO emptied, inflight=0, rsp_rdata=0.
- Address decode:
  - bank = req_addr[ADDR_W-1:9]; row = req_addr[8:0].
  - NUM_BANKS=1 means no bank bits.
- Macro pins are active-low:
  - CEN=0 enables the macro.
  - GWEN=0 selects write.
  - WEN per bit, 0 = write that bit.
  - Idle macros have CEN=1.
- INIT state:
  - Each cycle, all macros in all banks and lanes write INIT_VALUE at row clear_ptr; clear_ptr increments.
  - After the row 511 write, go to IDLE.
  - init_busy is high for exactly 512 cycles and falls in the cycle after the last write.
  - req_ready=0 throughout INIT.
  - init_start is ignored in INIT.
- IDLE state: req_ready = (fifo_count + inflight < 3). Same-cycle pop is not credited, so there is no rsp_ready->req_ready combinational path.
- Accepted write:
  - Selected bank's lanes with mask=1 get CEN=0, GWEN=0, WEN=8'h00, D=lane data.
  - Other lanes and banks get CEN=1.
  - req_wmask=0 is accepted and touches no macro.
- Accepted read:
  - Selected bank, all lanes: CEN=0, GWEN=1.
  - inflight=1; the bank index is registered.
  - Next cycle, Q of that bank's lanes is concatenated and pushed into the response FIFO.
  - inflight clears unless another read is accepted.
- Read latency: request handshake in cycle k -> rsp_valid in cycle k+2 at the earliest.
- Sustained throughput is 1 request/cycle with rsp_ready held high.
- Read-after-write to the same address returns the new data (macro sequential order); there is no bypass.
- Response FIFO:
  - 3 entries, in-order.
  - rsp_valid = !empty; rsp_rdata = head.
  - Pop on rsp_valid&&rsp_ready.
  - Push and pop in the same cycle leaves the count unchanged.
  - Overflow is impossible by the credit rule.
- init_start in IDLE:
  - State goes to INIT next cycle; no request is accepted in that cycle or after.
  - A read already in flight is still captured.
  - Existing FIFO entries remain deliverable during INIT.
- Requests with req_valid=0 cause no macro access.

Test Plan:
- Reset then release -> init_busy=1 and req_ready=0 for exactly 512 cycles. Then read addr 0, 511 and 0x3FF (NUM_BANKS=2) -> each returns 16'h0000 with INIT_VALUE=0.
- Write 16'hA55A to 0x005 and 16'h1234 to 0x205 (mask 2'b11), then read 0x005 then 0x205 back-to-back -> rsp 16'hA55A then 16'h1234; first rsp_valid two cycles after its handshake; req_ready never drops.
- After clear, write 16'hFFFF with mask 2'b01 to addr 7, read addr 7 -> 16'h00FF. Write with mask 2'b00 to addr 8 then read -> 16'h0000.
- Hold rsp_ready=0 and issue reads continuously -> exactly 3 accepted, then req_ready=0. Raise rsp_ready -> 3 responses in order, req_ready returns high.
- Assert rst_n low mid-stream with FIFO holding 2 entries -> rsp_valid and req_ready go 0 immediately without a clock edge. Release -> 512-cycle clear restarts, no stale response appears.
- Accept a read, pulse init_start the next cycle -> that read's data is delivered during INIT and init_busy rises. A second init_start pulse 100 cycles into INIT -> init_busy still falls 512 cycles after the first clear began.
